// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and shifts them out as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] pop_data,
  output logic       pop,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = pop_data;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          pop_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          idx_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next frame so back-to-back bytes have no idle gap
          if (!empty) begin
            shift_d = pop_data;
            state_d = S_START;
            tx_d    = 1'b0;
            pop_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop     = pop_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model, line decoder with byte scoreboard, table of single frames
// plus back-to-back, mid-frame reset and mid-frame empty-toggle sequences.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_FREQ  = 1600;
  localparam int BAUD_RATE = 100;
  localparam int BC        = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty;
  logic [7:0] pop_data;
  logic       pop, tx, busy, tx_done;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .empty(empty), .pop_data(pop_data),
    .pop(pop), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model; override lets a sequence drive empty/pop_data directly
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       ovr_en = 1'b0;
  logic       ovr_empty = 1'b1;
  logic [7:0] ovr_data = 8'h00;
  logic [7:0] sb [$];

  assign empty    = ovr_en ? ovr_empty : (rd_ptr == wr_ptr);
  assign pop_data = ovr_en ? ovr_data : fifo_mem[rd_ptr[5:0]];

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
    sb.push_back(b);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               pop_cnt = 0;
  int               done_cnt = 0;
  int               last_start = 0;
  int               prev_start = 0;
  bit               busy_at_done = 1'b0;
  bit               dec_active = 1'b0;
  int               dec_cnt = 0;
  int               dec_k;
  logic [NBITS-1:0] dec_line = '0;
  logic [7:0]       exp_b;

  always @(negedge clk) begin
    if (pop) begin
      pop_cnt++;
      check("pop_while_empty", empty, 0);
      if (!ovr_en && rd_ptr != wr_ptr) rd_ptr++;
    end
    if (tx_done) begin
      done_cnt++;
      busy_at_done = busy;
      check("frame_len", cyc - last_start, FRAME);
    end
    if (rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        prev_start = last_start;
        last_start = cyc;
        check("start_pop", pop, 1);
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BC == BC / 2) begin
        dec_k = dec_cnt / BC;
        dec_line[dec_k] = tx;
        if (dec_k == NBITS - 1) begin
          dec_active = 1'b0;
          check("stop_bit", dec_line[NBITS-1], 1);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_byte: got %0h expected none (scoreboard empty)", dec_line[8:1]);
          end else begin
            exp_b = sb.pop_front();
            check("rx_byte", dec_line[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", dec_line[9], ^exp_b);
`endif
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int start_cnt;
    int c;
    start_cnt = done_cnt;
    c = 0;
    while (done_cnt < start_cnt + n && c < budget) begin
      step();
      c++;
    end
    check(name, (done_cnt - start_cnt) >= n, 1);
  endtask

  task automatic wait_start(input int budget, input string name);
    int c;
    c = 0;
    while (!dec_active && c < budget) begin
      step();
      c++;
    end
    check(name, dec_active, 1);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit ok;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[6] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[7] = '{8'h0F, 10'b1_00001111_0, 1'b0};

    rst = 1'b1;
    repeat (3) step();
    check("rst_tx", tx, 1);
    check("rst_pop", pop, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    rst = 1'b0;

    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1 || pop !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("idle_quiet", ok, 1);

    for (int i = 0; i < 8; i++) begin
      p0 = pop_cnt;
      push_byte(vecs[i].data);
      wait_done(1, FRAME + 40, "done_timeout");
      check("busy_low_at_done", busy_at_done, 0);
      check("frame_line", {dec_line[NBITS-1], dec_line[8:0]}, vecs[i].line);
`ifdef UART_TX_PARITY_EN
      check("parity_tbl", dec_line[9], vecs[i].par);
`endif
      check("pops_per_frame", pop_cnt - p0, 1);
      step();
      check("done_pulse_width", tx_done, 0);
      check("busy_idle", busy, 0);
      repeat (5) step();
    end

    // back-to-back frames
    p0 = pop_cnt;
    push_byte(8'h55);
    push_byte(8'h0F);
    wait_done(2, 2 * FRAME + 40, "b2b_timeout");
    check("b2b_pops", pop_cnt - p0, 2);
    check("b2b_gap", last_start - prev_start, FRAME);
    check("b2b_busy_end", busy_at_done, 0);
    repeat (10) step();

    // reset in the middle of a frame
    p0 = pop_cnt;
    push_byte(8'hFF);
    wait_start(20, "rst_frame_start");
    for (int c = 0; c < 200 && (cyc - last_start) < 70; c++) step();
    rst = 1'b1;
    step();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_pop", pop, 0);
    rst = 1'b0;
    sb.delete();
    repeat (50) step();
    check("midrst_no_pop", pop_cnt - p0, 1);
    check("midrst_idle_busy", busy, 0);
    p0 = pop_cnt;
    push_byte(8'h3C);
    wait_done(1, FRAME + 40, "resume_timeout");
    check("resume_pops", pop_cnt - p0, 1);
    check("resume_line", {dec_line[NBITS-1], dec_line[8:0]}, 10'b1_00111100_0);
    repeat (10) step();

    // empty toggles and head byte changes mid-frame
    p0 = pop_cnt;
    push_byte(8'h96);
    wait_start(20, "tog_frame_start");
    repeat (40) step();
    ovr_data  = 8'h4B;
    ovr_empty = 1'b0;
    ovr_en    = 1'b1;
    repeat (30) step();
    ovr_data = 8'hE1;
    repeat (20) step();
    ovr_en    = 1'b0;
    ovr_empty = 1'b1;
    check("tog_no_extra_pop", pop_cnt - p0, 1);
    wait_done(1, FRAME + 40, "tog_timeout");
    check("tog_pops", pop_cnt - p0, 1);
    check("tog_line", {dec_line[NBITS-1], dec_line[8:0]}, 10'b1_10010110_0);
    repeat (20) step();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter draining the UART TX FIFO: whenever the FIFO is non-empty it pops one byte and shifts it out on `tx` as an 8N1 frame (optional parity). It sits directly downstream of the TX FIFO, wired to the FIFO's `empty`/`pop`/`pop_data` ports, and drives the board TX pin. Baud timing is derived internally from the system clock.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bit/s; `BIT_CYCLES = CLK_FREQ / BAUD_RATE` (integer divide), must be ≥ 2
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `empty`  in  1  FIFO empty flag
- `pop_data`  in  8  FIFO head byte; combinational, valid whenever `empty`=0
- `pop`  out  1  one-cycle pop strobe to FIFO
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a frame is in progress
- `tx_done`  out  1  one-cycle pulse at end of each stop bit

## Operation
- States: IDLE, START, DATA, (PARITY), STOP.
- Reset values: state=IDLE, `tx`=1, `pop`=0, `busy`=0, `tx_done`=0, bit-cycle counter=0, bit index=0, shift register=0.
- IDLE: if `empty`=0 at a rising edge → latch `pop_data` into shift register, state→START, `tx`→0, `busy`→1, counter cleared. `pop` is registered: high for exactly the one cycle after the latch edge.
- START: hold `tx`=0 for BIT_CYCLES cycles → DATA.
- DATA: 8 bits LSB first, each BIT_CYCLES cycles; bit index 0..7; after bit 7 → PARITY (if compiled) else STOP.
- STOP: `tx`=1 for BIT_CYCLES cycles. At the final cycle edge: `tx_done` pulses 1 cycle; if `empty`=0 → latch next byte, assert `pop`, go straight to START (zero idle gap); else → IDLE, `busy`→0.
- Counter width `$clog2(BIT_CYCLES)`; counts 0..BIT_CYCLES-1, wraps to 0 on each bit boundary.
- `pop` is never asserted while `empty`=1; never more than one pop per frame.
- `tx`, `busy`, `tx_done`, `pop` are all registered outputs (glitch-free pin).
- Reset mid-frame: next edge returns to reset values; `tx` goes high immediately, partial frame abandoned, already-popped byte discarded, no `pop` issued.
- `empty` going 0 mid-frame has no effect until the STOP boundary.

## Timing
- Latency: edge E where IDLE sees `empty`=0 → `tx` low and `pop` high after E; FIFO advances at E+1.
- Frame length: 10·BIT_CYCLES cycles (11·BIT_CYCLES with parity), start-bit edge to end of stop bit.
- Back-to-back frames: next start bit begins the cycle after the previous stop bit ends.
- FIFO `empty` is registered there, updating at E+1; transmitter does not sample it again until end of STOP, so no double-pop hazard.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after DATA; `tx` = even parity (XOR of the 8 data bits) for BIT_CYCLES cycles; frame = 11 bits.
- Undefined: no PARITY state, 8N1, 10-bit frame; parity logic absent from netlist.

## Test plan
All with CLK_FREQ=1600, BAUD_RATE=100 (BIT_CYCLES=16).
- Reset then `empty`=1 for 200 cycles → `tx`=1, `pop`=0, `busy`=0 throughout.
- `empty`=0, `pop_data`=8'hA5, FIFO model advances on `pop` and then empty → exactly one `pop` pulse; `tx` samples at bit centres = 0,1,0,1,0,0,1,0,1,1; `tx_done` pulse 160 cycles after start edge; `busy` low next cycle.
- FIFO holding 8'h55, 8'h0F → two pops, frames contiguous (no high gap between stop of first and start of second), decoded bytes 55h then 0Fh.
- `rst` asserted at cycle 70 of an 8'hFF frame → `tx`=1, `busy`=0 after the next edge, no further `pop`; resume with 8'h3C transmits correctly.
- With `UART_TX_PARITY_EN`, byte 8'h07 → parity bit 1, frame 176 cycles; byte 8'h03 → parity bit 0.
- `empty` toggles 0→1 mid-frame and bytes change on `pop_data` → transmitted byte is the one latched at frame start; no extra pop.
